// File: rtl/axil_mmio_responder_if.sv
// AXI4-Lite bus bundle between the XDMA lite master and the MMIO responder.
// The master modport is the host side; the slave modport is the register block.
interface axil_mmio_responder_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mmio_responder.sv
// AXI4-Lite register block behind the XDMA lite master: ID, scratch, 64-bit
// cycle counter with high-half snapshot, and exported control words.
module axil_mmio_responder #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hF1E5_0001
) (
    input  logic                        xdma_axi_aclk,
    input  logic                        xdma_axi_areset,
    axil_mmio_responder_if.slave        PCIE_M_AXI_LITE,
    output logic [32*(NUM_REGS-4)-1:0]  ctrl_regs,
    output logic [NUM_REGS-1:0]         reg_wr_pulse
);
    localparam int IDXW  = $clog2(NUM_REGS);
    localparam int NCTRL = NUM_REGS - 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic clk, rst;
    assign clk = xdma_axi_aclk;
    assign rst = xdma_axi_areset;

    logic [63:0]             counter;
    logic [31:0]             snapshot, scratch;
    logic [NCTRL-1:0][31:0]  ctrl;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) res[8*k +: 8] = s[k] ? d[8*k +: 8] : old[8*k +: 8];
        return res;
    endfunction

    // ---------------- write channel ----------------
    w_state_t        w_state, w_next;
    logic            aw_rdy, w_rdy, w_commit;
    logic [31:0]     aw_addr_q, w_data_q;
    logic [3:0]      w_strb_q;
    logic [31:0]     w_addr_eff, w_data_eff;
    logic [3:0]      w_strb_eff;
    logic [32:0]     w_off;
    logic            w_hit;
    logic [IDXW-1:0] w_idx;
    logic [1:0]      w_resp, bresp_q;

    // The final handshake may arrive in the commit cycle, so use live bus values then.
    assign w_addr_eff = (w_state == W_GOT_AW) ? aw_addr_q : PCIE_M_AXI_LITE.awaddr;
    assign w_data_eff = (w_state == W_GOT_W)  ? w_data_q  : PCIE_M_AXI_LITE.wdata;
    assign w_strb_eff = (w_state == W_GOT_W)  ? w_strb_q  : PCIE_M_AXI_LITE.wstrb;
    assign w_off      = {1'b0, w_addr_eff} - {1'b0, BASE_ADDR};
    assign w_hit      = !w_off[32] && (w_off[31:2] < 30'(NUM_REGS));
    assign w_idx      = w_off[IDXW+1:2];

    always_comb begin
        w_resp = RESP_OKAY;
        if (!w_hit)
            w_resp = RESP_DECERR;
        else if (w_idx == IDXW'(0) || w_idx == IDXW'(2) || w_idx == IDXW'(3))
            w_resp = RESP_SLVERR;
    end

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next   = w_state;
        aw_rdy   = 1'b0;
        w_rdy    = 1'b0;
        w_commit = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (PCIE_M_AXI_LITE.awvalid && PCIE_M_AXI_LITE.wvalid) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end else if (PCIE_M_AXI_LITE.awvalid) w_next = W_GOT_AW;
                else if (PCIE_M_AXI_LITE.wvalid)      w_next = W_GOT_W;
            end
            W_GOT_AW: begin
                w_rdy = 1'b1;
                if (PCIE_M_AXI_LITE.wvalid) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_GOT_W: begin
                aw_rdy = 1'b1;
                if (PCIE_M_AXI_LITE.awvalid) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP:  if (PCIE_M_AXI_LITE.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    assign PCIE_M_AXI_LITE.awready = aw_rdy && !rst;
    assign PCIE_M_AXI_LITE.wready  = w_rdy && !rst;
    assign PCIE_M_AXI_LITE.bvalid  = (w_state == W_RESP);
    assign PCIE_M_AXI_LITE.bresp   = bresp_q;

    // ---------------- read channel ----------------
    r_state_t        r_state, r_next;
    logic            ar_rdy;
    logic [32:0]     r_off;
    logic            r_hit;
    logic [IDXW-1:0] r_idx;
    logic [31:0]     r_data_d, rdata_q;
    logic [1:0]      r_resp_d, rresp_q;

    assign r_off = {1'b0, PCIE_M_AXI_LITE.araddr} - {1'b0, BASE_ADDR};
    assign r_hit = !r_off[32] && (r_off[31:2] < 30'(NUM_REGS));
    assign r_idx = r_off[IDXW+1:2];

    always_comb begin
        r_data_d = '0;
        r_resp_d = RESP_DECERR;
        if (r_hit) begin
            r_resp_d = RESP_OKAY;
            case (r_idx)
                IDXW'(0): r_data_d = ID_VALUE;
                IDXW'(1): r_data_d = scratch;
                IDXW'(2): r_data_d = counter[31:0];
                IDXW'(3): r_data_d = snapshot;
                default:
                    for (int i = 0; i < NCTRL; i++)
                        if (r_idx == IDXW'(i + 4)) r_data_d = ctrl[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (PCIE_M_AXI_LITE.arvalid) r_next = R_DATA;
            end
            R_DATA:  if (PCIE_M_AXI_LITE.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign PCIE_M_AXI_LITE.arready = ar_rdy && !rst;
    assign PCIE_M_AXI_LITE.rvalid  = (r_state == R_DATA);
    assign PCIE_M_AXI_LITE.rdata   = rdata_q;
    assign PCIE_M_AXI_LITE.rresp   = rresp_q;

    // ---------------- register bank ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            snapshot     <= '0;
            scratch      <= '0;
            ctrl         <= '0;
            reg_wr_pulse <= '0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
        end else begin
            counter      <= counter + 64'd1;
            reg_wr_pulse <= '0;
            if (aw_rdy && PCIE_M_AXI_LITE.awvalid) aw_addr_q <= PCIE_M_AXI_LITE.awaddr;
            if (w_rdy && PCIE_M_AXI_LITE.wvalid) begin
                w_data_q <= PCIE_M_AXI_LITE.wdata;
                w_strb_q <= PCIE_M_AXI_LITE.wstrb;
            end
            if (w_commit) begin
                bresp_q <= w_resp;
                if (w_resp == RESP_OKAY) begin
                    reg_wr_pulse[w_idx] <= 1'b1;
                    if (w_idx == IDXW'(1)) scratch <= merge(scratch, w_data_eff, w_strb_eff);
                    for (int i = 0; i < NCTRL; i++)
                        if (w_idx == IDXW'(i + 4)) ctrl[i] <= merge(ctrl[i], w_data_eff, w_strb_eff);
                end
            end
            // Same-edge read of a word being written sees the old value.
            if (ar_rdy && PCIE_M_AXI_LITE.arvalid) begin
                rdata_q <= r_data_d;
                rresp_q <= r_resp_d;
                if (r_hit && r_idx == IDXW'(2)) snapshot <= counter[63:32];
            end
        end
    end

    assign ctrl_regs = ctrl;

    logic unused_ok;
    assign unused_ok = ^{PCIE_M_AXI_LITE.awprot, PCIE_M_AXI_LITE.arprot, w_off[1:0], r_off[1:0]};
endmodule

// File: doc/axil_mmio_responder.md
Name: axil_mmio_responder

Overview:
AXI4-Lite subordinate at the custom-logic end of the XDMA's PCIE_M_AXI_LITE master port; it answers host MMIO reads and writes. Holds a small bank of 32-bit control/status registers (ID, scratch, 64-bit cycle counter, generic control) and exports the control registers and write pulses to simulation-control logic. Independent write and read state machines; one outstanding transaction per direction.

Parameters:
NUM_REGS, 16, number of 32-bit words decoded (min 5, max 256)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
ID_VALUE, 32'hF1E5_0001, read-only value of word 0

Ports:
xdma_axi_aclk  in  1  clock, the XDMA AXI clock
xdma_axi_areset  in  1  synchronous active-high reset
PCIE_M_AXI_LITE_awaddr  in  32  write address
PCIE_M_AXI_LITE_awprot  in  3  ignored
PCIE_M_AXI_LITE_awvalid / _awready  in / out  1  AW handshake
PCIE_M_AXI_LITE_wdata  in  32  write data
PCIE_M_AXI_LITE_wstrb  in  4  byte enables
PCIE_M_AXI_LITE_wvalid / _wready  in / out  1  W handshake
PCIE_M_AXI_LITE_bresp  out  2  write response
PCIE_M_AXI_LITE_bvalid / _bready  out / in  1  B handshake
PCIE_M_AXI_LITE_araddr  in  32  read address
PCIE_M_AXI_LITE_arprot  in  3  ignored
PCIE_M_AXI_LITE_arvalid / _arready  in / out  1  AR handshake
PCIE_M_AXI_LITE_rdata  out  32  read data
PCIE_M_AXI_LITE_rresp  out  2  read response
PCIE_M_AXI_LITE_rvalid / _rready  out / in  1  R handshake
ctrl_regs  out  32*(NUM_REGS-4)  flat contents of words 4..NUM_REGS-1, word 4 in LSBs
reg_wr_pulse  out  NUM_REGS  one-cycle pulse, bit i = word i committed by a write

Behaviour:
- Register map (word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored): 0 ID (RO); 1 scratch (RW); 2 counter low (RO); 3 counter high snapshot (RO); 4..NUM_REGS-1 control (RW).
- Counter: 64-bit, +1 every cycle, wraps 2^64-1 -> 0. Reading word 2 returns live low half and loads word 3 with the high half in the same cycle; word 3 read returns the snapshot.
- Decode: addr < BASE_ADDR or index >= NUM_REGS -> DECERR (2'b11), reads return 0, writes no effect. Write to words 0/2/3 -> SLVERR (2'b10), no effect. Otherwise OKAY (2'b00).
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - awready=1 in W_IDLE and W_GOT_W; wready=1 in W_IDLE and W_GOT_AW; both 0 in W_RESP.
  - AW and W may complete in the same cycle or either order; captured addr/data/strb held.
  - Commit in the cycle after both are held: per-byte update where wstrb[k]=1; reg_wr_pulse[idx] high that cycle (OKAY only); go W_RESP with bvalid=1, bresp registered.
  - bvalid, bresp stable until bready; on bvalid&bready -> W_IDLE. Minimum AW+W to bvalid latency: 1 cycle.
- Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
  - On arvalid&arready: decode, register rdata/rresp, rvalid=1 next cycle.
  - rdata/rresp stable until rready; on rvalid&rready -> R_IDLE. No back-to-back acceptance in the response cycle.
- Simultaneous read and write commit to same word: read returns pre-write value.
- Reset (any cycle, including mid-transaction): all readys 0 during reset, bvalid=rvalid=0, bresp=rresp=0, rdata=0, all RW registers and counter/snapshot 0, reg_wr_pulse=0, FSMs to idle; in-flight transactions dropped without response. Readys assert the cycle after reset deasserts.
- No combinational path from any input valid/ready to any output.

Test Plan:
- Read word 0 after reset -> rdata=32'hF1E5_0001, rresp=0, rvalid 1 cycle after AR handshake.
- AW at cycle n, W at n+3 to word 1 data 32'hA5A5_1234 strb 4'hF -> bvalid at n+4, bresp=0; read word 1 -> 32'hA5A5_1234. Repeat with W before AW, same result.
- Write word 4 data 32'hFFFF_FFFF strb 4'b0101 over 32'h0 -> ctrl_regs[31:0]=32'h00FF_00FF, reg_wr_pulse[4] high exactly 1 cycle.
- Write word 0 -> bresp=2'b10, ID unchanged; read index NUM_REGS -> rresp=2'b11, rdata=0; write there -> bresp=2'b11, no reg_wr_pulse.
- Hold bready=0 / rready=0 for 10 cycles -> bvalid/rvalid, bresp/rdata stable, awready/wready/arready stay 0; counter read word 2 then word 3 -> high half equals counter high at word-2 read.
- Assert reset while in W_GOT_AW and R_DATA -> bvalid=rvalid=0 next cycle, scratch reads 0 after release, no stale response issued.
